// File: rtl/regbus_arbiter.sv
// regbus_arbiter: two-port arbiter/sequencer for the register bus.
// Port 0 is the SPI instruction decoder and port 1 is the internal update
// engine. One access is granted at a time. The module sequences the one-cycle
// register-file read latency and returns a one-cycle ack, plus err and rdata.
// Addresses above MAX_ADDR never reach the register file. They are acked with
// err=1.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   req/we/addr/wdata 0/1         requester command (held stable while req high)
//   ack/err/rdata 0/1             per-port completion, rejection flag, read data
//   read, write, addr, data_write register-file strobes, address and write data
//   data_read                     register-file read data, valid cycle after read
//   busy                          high from grant until the cycle before ack
module regbus_arbiter #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned MAX_ADDR   = 32'h3F,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  output logic              ack1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_write,
  input  logic [DATA_W-1:0] data_read,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;   // port served most recently (1 = port 1)
  logic   gnt_q, gnt_d;     // port currently being served
  logic   we_q, we_d;
  logic   bad_q, bad_d;     // latched address was out of range

  logic              ack0_d, ack1_d, err0_d, err1_d;
  logic [DATA_W-1:0] rdata0_d, rdata1_d, data_write_d;
  logic              read_d, write_d, busy_d;
  logic [ADDR_W-1:0] addr_d;

  logic              elig0, elig1, sel1, sel_we, sel_bad;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    bad_d        = bad_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    read_d       = 1'b0;
    write_d      = 1'b0;
    rdata0_d     = rdata0;
    rdata1_d     = rdata1;
    addr_d       = addr;
    data_write_d = data_write;
    busy_d       = busy;

    // A port being acked this cycle sits out one arbitration round
    elig0     = req0 & ~ack0;
    elig1     = req1 & ~ack1;
    sel1      = elig1 & (~elig0 | (~FIXED_PRIO & ~last_q));
    sel_we    = sel1 ? we1 : we0;
    sel_addr  = sel1 ? addr1 : addr0;
    sel_wdata = sel1 ? wdata1 : wdata0;
    sel_bad   = 32'(sel_addr) > MAX_ADDR;

    case (state_q)
      IDLE: begin
        if (elig0 | elig1) begin
          gnt_d   = sel1;
          last_d  = sel1;
          we_d    = sel_we;
          bad_d   = sel_bad;
          busy_d  = 1'b1;
          state_d = ACCESS;
          if (!sel_bad) begin
            read_d  = ~sel_we;
            write_d = sel_we;
            addr_d  = sel_addr;
            if (sel_we) data_write_d = sel_wdata;
          end
        end
      end
      ACCESS: state_d = CAPTURE;
      CAPTURE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (gnt_q) begin
          ack1_d = 1'b1;
          err1_d = bad_q;
          if (!we_q) rdata1_d = bad_q ? '0 : data_read;
        end else begin
          ack0_d = 1'b1;
          err0_d = bad_q;
          if (!we_q) rdata0_d = bad_q ? '0 : data_read;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      bad_q      <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      addr       <= '0;
      data_write <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      bad_q      <= bad_d;
      ack0       <= ack0_d;
      ack1       <= ack1_d;
      err0       <= err0_d;
      err1       <= err1_d;
      rdata0     <= rdata0_d;
      rdata1     <= rdata1_d;
      read       <= read_d;
      write      <= write_d;
      addr       <= addr_d;
      data_write <= data_write_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_regbus_arbiter.sv
// Testbench for regbus_arbiter (MAX_ADDR=1F, round-robin). A per-cycle
// transaction model predicts every output, and directed scenarios add
// explicit checks. Random traffic then runs against the same model.
module tb_regbus_arbiter;

  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 8;
  localparam int unsigned MAX_A = 32'h1F;

  logic          clk, rst_n;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, err0, ack1, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic          read, write, busy;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_write, data_read;

  regbus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_ADDR(MAX_A), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .read(read), .write(write), .addr(addr), .data_write(data_write),
    .data_read(data_read), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Read-only register file contents; the DUT's writes are checked on the bus
  logic [DW-1:0] mem [64];
  always @(posedge clk) data_read <= read ? mem[addr] : DW'($urandom);

  // Reference model: m_phase counts cycles since grant (0 = free)
  int            m_phase;
  int            m_gnt, m_last;
  logic          lat_we;
  logic [AW-1:0] lat_a;
  logic [DW-1:0] lat_d;
  logic [1:0]    m_ack, m_err, m_el;
  logic [DW-1:0] m_rdata [2];
  logic          m_read, m_write, m_busy;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_dw;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_gnt = 0; m_last = 1;
      m_ack = '0; m_err = '0; m_rdata[0] = '0; m_rdata[1] = '0;
      m_read = 0; m_write = 0; m_busy = 0; m_addr = '0; m_dw = '0;
      lat_we = 0; lat_a = '0; lat_d = '0;
    end else begin
      m_el = {req1, req0} & ~m_ack;
      m_ack = '0; m_err = '0; m_read = 0; m_write = 0;
      if (m_phase == 1) begin
        m_phase = 2;
      end else if (m_phase == 2) begin
        m_phase = 0;
        m_busy = 0;
        m_ack[m_gnt] = 1'b1;
        m_err[m_gnt] = (32'(lat_a) > MAX_A);
        if (!lat_we) m_rdata[m_gnt] = (32'(lat_a) > MAX_A) ? '0 : mem[lat_a];
      end else if (m_el != 2'b00) begin
        if (m_el == 2'b11) m_gnt = 1 - m_last;
        else m_gnt = m_el[0] ? 0 : 1;
        m_last = m_gnt;
        lat_we = m_gnt ? we1 : we0;
        lat_a  = m_gnt ? addr1 : addr0;
        lat_d  = m_gnt ? wdata1 : wdata0;
        m_phase = 1;
        m_busy = 1;
        if (32'(lat_a) <= MAX_A) begin
          m_read = !lat_we;
          m_write = lat_we;
          m_addr = lat_a;
          if (lat_we) m_dw = lat_d;
        end
      end
    end
  end

  // Compare every output against the model mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      check("ack0", ack0, m_ack[0]);
      check("ack1", ack1, m_ack[1]);
      if (m_ack[0]) check("err0", err0, m_err[0]);
      if (m_ack[1]) check("err1", err1, m_err[1]);
      check("rdata0", rdata0, m_rdata[0]);
      check("rdata1", rdata1, m_rdata[1]);
      check("read", read, m_read);
      check("write", write, m_write);
      check("busy", busy, m_busy);
      check("addr", addr, m_addr);
      check("data_write", data_write, m_dw);
      check("ack_excl", ack0 & ack1, 0);
    end
  end

  task automatic set_req(input int p, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  // Advance until port p acks (bounded); counts strobe cycles seen on the way
  task automatic wait_ack(input int p, input string tag, output int strobes);
    int n;
    logic a;
    n = 0; strobes = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (read | write) strobes++;
      a = (p == 0) ? ack0 : ack1;
    end while (!a && n < 20);
    check({tag, "_ack"}, a, 1);
  endtask

  int st;
  int c;
  int rd_cyc[$];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = DW'($urandom);
    mem[6'h10] = 8'h3C;
    rst_n = 1'b0;
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    #12;
    check("rst_busy", busy, 0);
    check("rst_strobes", {read, write}, 0);
    check("rst_acks", {ack0, ack1, err0, err1}, 0);
    check("rst_rdata", {rdata0, rdata1}, 0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // Legal write on port 0
    set_req(0, 1, 1, 6'h05, 8'hA5);
    wait_ack(0, "t1", st);
    set_req(0, 0, 0, '0, '0);
    check("t1_strobes", st, 1);
    check("t1_err", err0, 0);
    check("t1_addr", addr, 6'h05);
    check("t1_dw", data_write, 8'hA5);

    // Legal read on port 1
    set_req(1, 1, 0, 6'h10, 8'h00);
    wait_ack(1, "t2", st);
    set_req(1, 0, 0, '0, '0);
    check("t2_rdata", rdata1, 8'h3C);
    check("t2_err", err1, 0);
    repeat (2) @(posedge clk);
    #1;

    // Both held: strobes on C1, C4, C7, C10
    set_req(0, 1, 0, 6'h01, 8'h00);
    set_req(1, 1, 0, 6'h02, 8'h00);
    for (int k = 1; k < 12; k++) begin
      @(posedge clk); #1;
      if (read) rd_cyc.push_back(k);
    end
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    check("t3_nstrobe", rd_cyc.size(), 4);
    for (int k = 0; k < rd_cyc.size() && k < 4; k++) check("t3_cycle", rd_cyc[k], 1 + 3 * k);
    repeat (4) @(posedge clk);
    #1;

    // Out-of-range read
    set_req(0, 1, 0, 6'h3F, 8'h00);
    wait_ack(0, "t4", st);
    set_req(0, 0, 0, '0, '0);
    check("t4_strobes", st, 0);
    check("t4_err", err0, 1);
    check("t4_rdata", rdata0, 0);
    @(posedge clk); #1;

    // Reset during ACCESS drops the transfer
    set_req(0, 1, 1, 6'h07, 8'h11);
    @(posedge clk); #1;
    check("t5_pre_write", write, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_strobes", {read, write}, 0);
    set_req(0, 0, 0, '0, '0);
    @(negedge clk);
    check("t5_noack", {ack0, ack1}, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    set_req(1, 1, 0, 6'h10, 8'h00);
    wait_ack(1, "t5b", st);
    set_req(1, 0, 0, '0, '0);
    check("t5_rdata", rdata1, 8'h3C);
    @(posedge clk); #1;

    // Request held through ack with a new command
    set_req(0, 1, 0, 6'h05, 8'h00);
    wait_ack(0, "t6", st);
    set_req(0, 1, 0, 6'h06, 8'h00);
    @(posedge clk); #1;
    check("t6_nodup", read, 0);
    @(posedge clk); #1;
    check("t6_read", read, 1);
    check("t6_addr", addr, 6'h06);
    set_req(0, 0, 0, '0, '0);
    repeat (3) @(posedge clk);
    #1;

    // Random traffic checked by the model
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        logic r;
        r = (p == 0) ? req0 : req1;
        if (m_ack[p]) begin
          if ($urandom_range(1, 0) == 0) set_req(p, 0, 0, '0, '0);
          else set_req(p, 1, 1'($urandom),
                       ($urandom_range(3, 0) == 0) ? AW'($urandom) : AW'($urandom_range(31, 0)),
                       DW'($urandom));
        end else if (!r && $urandom_range(3, 0) == 0) begin
          set_req(p, 1, 1'($urandom),
                  ($urandom_range(3, 0) == 0) ? AW'($urandom) : AW'($urandom_range(31, 0)),
                  DW'($urandom));
        end
      end
      @(posedge clk); #1;
    end
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    repeat (5) @(posedge clk);
    #1;
    c = n_checks;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
